sparc_ram_loader: RTL and testbench

Program loader that sits directly upstream of the SPARC MPU's memory. It accepts a byte stream of the program image over a valid/ready handshake and writes it into RAM, one byte per MOV/MFC memory transaction, starting at address 0. While loading, it holds the MPU in clear. After the last byte plus a fixed release delay, it drops the clear so the MPU starts fetching from address 0.

---
 rtl/sparc_ram_loader.sv | 188 ++++++++++++++++++
 tb/tb_sparc_ram_loader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparc_ram_loader.sv
// Program loader for the SPARC MPU: streams an image into RAM from address 0
// over MOV/MFC byte writes, holding the MPU in clear until the image is in place.
module sparc_ram_loader #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned MFC_TIMEOUT = 15,
    parameter int unsigned RELEASE_DLY = 2
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_mov,
    output logic              ram_rw,
    output logic [1:0]        ram_type,
    input  logic              ram_mfc,
    output logic              cpu_clr,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   byte_count
);

    localparam int unsigned CNT_W    = ADDR_W + 1;
    localparam int unsigned TMR_MAX  = (MFC_TIMEOUT > RELEASE_DLY) ? MFC_TIMEOUT : RELEASE_DLY;
    localparam int unsigned TMR_W    = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);
    localparam int unsigned MFC_LAST = (MFC_TIMEOUT > 0) ? MFC_TIMEOUT - 1 : 0;
    localparam int unsigned REL_LAST = (RELEASE_DLY > 0) ? RELEASE_DLY - 1 : 0;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_BYTE = 3'd1;
    localparam logic [2:0] ST_WRITE     = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;
    localparam logic [2:0] ST_ERROR     = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              mov_q, mov_d;
    logic              rw_q, rw_d;
    logic              ready_q, ready_d;
    logic              clr_q, clr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [TMR_W-1:0]  timer_inc;

    // Saturating timer increment, shared by the MFC watchdog and release delay
    assign timer_inc = (timer_q == TMR_W'(TMR_MAX)) ? timer_q : timer_q + TMR_W'(1);

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            mov_q   <= 1'b0;
            rw_q    <= 1'b1;
            ready_q <= 1'b0;
            clr_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mov_q   <= mov_d;
            rw_q    <= rw_d;
            ready_q <= ready_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mov_d   = mov_q;
        rw_d    = rw_q;
        ready_d = ready_q;
        clr_d   = clr_q;
        done_d  = done_q;
        err_d   = err_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    addr_d  = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    clr_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = ST_WAIT_BYTE;
                end
            end
            ST_WAIT_BYTE: begin
                if (in_valid && ready_q) begin
                    data_d  = in_byte;
                    last_d  = in_last;
                    rw_d    = 1'b0;
                    mov_d   = 1'b1;
                    ready_d = 1'b0;
                    timer_d = '0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (ram_mfc) begin
                    mov_d = 1'b0;
                    rw_d  = 1'b1;
                    if (cnt_q != CNT_W'(DEPTH)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (last_q) begin
                        timer_d = '0;
                        state_d = ST_RELEASE;
                    end else if (addr_q == ADDR_W'(DEPTH - 1)) begin
                        // Image does not fit: stop without wrapping to address 0
                        err_d   = 1'b1;
                        clr_d   = 1'b1;
                        ready_d = 1'b0;
                        state_d = ST_ERROR;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        ready_d = 1'b1;
                        state_d = ST_WAIT_BYTE;
                    end
                end else if (timer_q == TMR_W'(MFC_LAST)) begin
                    mov_d   = 1'b0;
                    rw_d    = 1'b1;
                    err_d   = 1'b1;
                    clr_d   = 1'b1;
                    ready_d = 1'b0;
                    state_d = ST_ERROR;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_RELEASE: begin
                clr_d = 1'b1;
                if (timer_q == TMR_W'(REL_LAST)) begin
                    clr_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_ERROR: begin
                err_d   = 1'b1;
                clr_d   = 1'b1;
                ready_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready   = ready_q;
    assign ram_addr   = addr_q;
    assign ram_data   = data_q;
    assign ram_mov    = mov_q;
    assign ram_rw     = rw_q;
    assign ram_type   = 2'b00;
    assign cpu_clr    = clr_q;
    assign done       = done_q;
    assign error      = err_q;
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_sparc_ram_loader.sv
// Directed bench for sparc_ram_loader: a MOV/MFC memory model with adjustable
// latency logs every completed write; the main sequence checks timing and results.
module tb_sparc_ram_loader;

    logic       Clk = 1'b0;
    logic       Clr = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [8:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_mov;
    logic       ram_rw;
    logic [1:0] ram_type;
    logic       ram_mfc = 1'b0;
    logic       cpu_clr;
    logic       done;
    logic       error;
    logic [9:0] byte_count;

    sparc_ram_loader dut (
        .Clk        (Clk),
        .Clr        (Clr),
        .start      (start),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_mov    (ram_mov),
        .ram_rw     (ram_rw),
        .ram_type   (ram_type),
        .ram_mfc    (ram_mfc),
        .cpu_clr    (cpu_clr),
        .done       (done),
        .error      (error),
        .byte_count (byte_count)
    );

    always #5 Clk = ~Clk;

    int         n_chk = 0;
    int         n_fail = 0;
    int         mfc_dly = 1;
    bit         mfc_en = 1'b1;
    int         mfc_wait = 0;
    int         wr_count = 0;
    int         ready_viol = 0;
    logic [8:0] log_addr [0:2047];
    logic [7:0] log_data [0:2047];
    logic [7:0] exp_data [0:1023];

    // Memory model: raise MFC after mfc_dly cycles of a pending write
    always @(negedge Clk) begin
        if (ram_mov && !ram_rw && mfc_en) begin
            mfc_wait <= mfc_wait + 1;
            ram_mfc  <= (mfc_wait + 1 >= mfc_dly);
        end else begin
            mfc_wait <= 0;
            ram_mfc  <= 1'b0;
        end
        if (ram_mov && in_ready) ready_viol <= ready_viol + 1;
    end

    always @(posedge Clk) begin
        if (!Clr && ram_mov && !ram_rw && ram_mfc && wr_count < 2048) begin
            log_addr[wr_count] <= ram_addr;
            log_data[wr_count] <= ram_data;
            wr_count <= wr_count + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Offer a byte; returns at the negedge after the accepting edge
    task automatic send(input logic [7:0] b, input logic l, output bit ok);
        in_byte  = b;
        in_last  = l;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        if (ok) cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && done !== 1'b1; i++) cyc();
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_data"}, 32'(ram_data), 32'd0);
        chk({tag, "_mov"}, 32'(ram_mov), 32'd0);
        chk({tag, "_rw"}, 32'(ram_rw), 32'd1);
        chk({tag, "_type"}, 32'(ram_type), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_cpuclr"}, 32'(cpu_clr), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_count"}, 32'(byte_count), 32'd0);
    endtask

    task automatic check_seq(input int base, input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (log_addr[base+i] !== 9'(i) || log_data[base+i] !== exp_data[i]) bad++;
        end
        chk({tag, "_nwr"}, 32'(wr_count - base), 32'(n));
        chk({tag, "_seq"}, 32'(bad), 32'd0);
    endtask

    initial begin
        bit ok;
        int base;
        int n;

        // Reset
        cyc();
        cyc();
        check_reset("rst");
        Clr = 1'b0;
        cyc();

        // start with in_valid in IDLE: only start acts
        in_byte  = 8'hEE;
        in_valid = 1'b1;
        start    = 1'b1;
        cyc();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("idle_valid_mov", 32'(ram_mov), 32'd0);
        chk("idle_valid_ready", 32'(in_ready), 32'd1);

        // Basic load, MFC one cycle after MOV
        mfc_dly = 1;
        base = wr_count;
        exp_data[0] = 8'h81; exp_data[1] = 8'hC0; exp_data[2] = 8'h20; exp_data[3] = 8'h0A;
        send(8'h81, 1'b0, ok);
        chk("basic_mov", 32'(ram_mov), 32'd1);
        chk("basic_rw", 32'(ram_rw), 32'd0);
        chk("basic_data0", 32'(ram_data), 32'h81);
        chk("basic_ready_wr", 32'(in_ready), 32'd0);
        send(8'hC0, 1'b0, ok);
        send(8'h20, 1'b0, ok);
        send(8'h0A, 1'b1, ok);
        cyc();
        chk("basic_rel_clr", 32'(cpu_clr), 32'd1);
        chk("basic_rel_done", 32'(done), 32'd0);
        cyc();
        chk("basic_rel1_done", 32'(done), 32'd0);
        cyc();
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_cpuclr", 32'(cpu_clr), 32'd0);
        chk("basic_count", 32'(byte_count), 32'd4);
        chk("basic_addr", 32'(ram_addr), 32'd3);
        check_seq(base, 4, "basic");

        // Reload from DONE
        pulse_start();
        chk("reload_cpuclr", 32'(cpu_clr), 32'd1);
        chk("reload_done", 32'(done), 32'd0);
        chk("reload_count", 32'(byte_count), 32'd0);
        chk("reload_ready", 32'(in_ready), 32'd1);
        base = wr_count;
        exp_data[0] = 8'h5A;
        send(8'h5A, 1'b1, ok);
        wait_done(20, "reload_finish");
        check_seq(base, 1, "reload");
        chk("reload_addr", 32'(ram_addr), 32'd0);

        // Clr and start together: Clr wins
        Clr   = 1'b1;
        start = 1'b1;
        cyc();
        Clr   = 1'b0;
        start = 1'b0;
        chk("clrstart_ready", 32'(in_ready), 32'd0);
        chk("clrstart_done", 32'(done), 32'd0);

        // MFC timeout
        mfc_en = 1'b0;
        pulse_start();
        send(8'h77, 1'b0, ok);
        repeat (14) cyc();
        chk("tmo_e14_error", 32'(error), 32'd0);
        chk("tmo_e14_mov", 32'(ram_mov), 32'd1);
        cyc();
        chk("tmo_error", 32'(error), 32'd1);
        chk("tmo_mov", 32'(ram_mov), 32'd0);
        chk("tmo_rw", 32'(ram_rw), 32'd1);
        chk("tmo_cpuclr", 32'(cpu_clr), 32'd1);
        chk("tmo_ready", 32'(in_ready), 32'd0);
        pulse_start();
        cyc();
        chk("tmo_start_error", 32'(error), 32'd1);
        chk("tmo_start_ready", 32'(in_ready), 32'd0);
        Clr = 1'b1;
        cyc();
        Clr = 1'b0;
        check_reset("tmo_clr");
        mfc_en = 1'b1;

        // Clr during the second write, then a fresh 2-byte load
        mfc_dly = 4;
        pulse_start();
        send(8'hA1, 1'b0, ok);
        send(8'hA2, 1'b0, ok);
        chk("midclr_inwrite", 32'(ram_mov), 32'd1);
        Clr = 1'b1;
        cyc();
        Clr = 1'b0;
        check_reset("midclr");
        base = wr_count;
        exp_data[0] = 8'hB1; exp_data[1] = 8'hB2;
        pulse_start();
        send(8'hB1, 1'b0, ok);
        send(8'hB2, 1'b1, ok);
        wait_done(40, "midclr_finish");
        check_seq(base, 2, "midclr");
        chk("midclr_count", 32'(byte_count), 32'd2);

        // Backpressure (3-cycle gaps) with 5-cycle memory
        mfc_dly = 5;
        base = wr_count;
        exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33;
        pulse_start();
        repeat (3) cyc();
        send(8'h11, 1'b0, ok);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (ram_mov !== 1'b1) break;
            n++;
            cyc();
        end
        chk("bp_mov_cycles", 32'(n), 32'd5);
        chk("bp_addr1", 32'(ram_addr), 32'd1);
        repeat (3) cyc();
        send(8'h22, 1'b0, ok);
        repeat (3) cyc();
        send(8'h33, 1'b1, ok);
        wait_done(40, "bp_finish");
        check_seq(base, 3, "bp");
        chk("bp_ready_in_write", 32'(ready_viol), 32'd0);

        // Overflow: 513 bytes, last only on the 513th
        mfc_dly = 1;
        base = wr_count;
        for (int i = 0; i < 512; i++) exp_data[i] = 8'(i * 7 + 3);
        pulse_start();
        for (int i = 0; i < 512; i++) send(8'(i * 7 + 3), 1'b0, ok);
        send(8'hFF, 1'b1, ok);
        chk("ovf_513_rejected", 32'(ok), 32'd0);
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_count", 32'(byte_count), 32'd512);
        chk("ovf_addr", 32'(ram_addr), 32'd511);
        chk("ovf_cpuclr", 32'(cpu_clr), 32'd1);
        check_seq(base, 512, "ovf");

        // Exactly 512 bytes fill the RAM legally
        Clr = 1'b1;
        cyc();
        Clr = 1'b0;
        base = wr_count;
        for (int i = 0; i < 512; i++) exp_data[i] = 8'(i ^ 8'h5C);
        pulse_start();
        for (int i = 0; i < 512; i++) send(8'(i ^ 8'h5C), (i == 511), ok);
        wait_done(20, "full_finish");
        chk("full_error", 32'(error), 32'd0);
        chk("full_count", 32'(byte_count), 32'd512);
        chk("full_addr", 32'(ram_addr), 32'd511);
        check_seq(base, 512, "full");
        chk("final_ready_in_write", 32'(ready_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
